regfile_exec_unit: RTL and testbench

Parametrised register file with an integrated sequencing ALU. It is the next generation of the team's 16×16 register bank plus ALU datapath, with configurable width and depth and an op-level valid/ready handshake. Shifts run iteratively, one bit per cycle, and the flag register is owned by the block and updated per opcode. It sits between the instruction decoder, which issues ops, and the rest of the CPU datapath, which observes results through the debug read port and the flags.

---
 rtl/regfile_pkg.sv | 57 +++++
 rtl/regfile_exec_unit_bank.sv | 42 ++++
 rtl/regfile_exec_unit.sv | 193 +++++++++++++++++++
 tb/tb_regfile_exec_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared opcode encodings, flag bit positions, FSM states and opcode
// classification helpers for the register-file execution unit.
package regfile_pkg;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_ADDI = 8'h01;
  localparam logic [7:0] OP_ADDU = 8'h02;
  localparam logic [7:0] OP_ADDC = 8'h04;
  localparam logic [7:0] OP_SUB  = 8'h08;
  localparam logic [7:0] OP_SUBI = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0A;
  localparam logic [7:0] OP_CMPI = 8'h0B;
  localparam logic [7:0] OP_CMPU = 8'h0C;
  localparam logic [7:0] OP_AND  = 8'h0D;
  localparam logic [7:0] OP_OR   = 8'h0E;
  localparam logic [7:0] OP_XOR  = 8'h0F;
  localparam logic [7:0] OP_NOT  = 8'h10;
  localparam logic [7:0] OP_LSH  = 8'h11;
  localparam logic [7:0] OP_LSHI = 8'h12;
  localparam logic [7:0] OP_RSH  = 8'h13;
  localparam logic [7:0] OP_RSHI = 8'h14;
  localparam logic [7:0] OP_ARSH = 8'h16;
  localparam logic [7:0] OP_NOP  = 8'h17;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_imm(input logic [7:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI) ||
           (op == OP_LSHI) || (op == OP_RSHI);
  endfunction

  function automatic logic is_shift(input logic [7:0] op);
    return (op == OP_LSH) || (op == OP_LSHI) || (op == OP_RSH) ||
           (op == OP_RSHI) || (op == OP_ARSH);
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBI, OP_CMP, OP_CMPI,
      OP_CMPU, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_LSHI, OP_RSH,
      OP_RSHI, OP_ARSH, OP_NOP: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_exec_unit_bank.sv
// NREGS x WIDTH register array: three asynchronous read ports, one
// synchronous write port, asynchronous active-low clear.
module regfile_bank #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && (int'(waddr) < NREGS)) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Addresses past NREGS (non power-of-two depth) read as zero.
  assign ra_data  = (int'(ra_addr)  < NREGS) ? mem_q[ra_addr]  : '0;
  assign rb_data  = (int'(rb_addr)  < NREGS) ? mem_q[rb_addr]  : '0;
  assign dbg_data = (int'(dbg_addr) < NREGS) ? mem_q[dbg_addr] : '0;

endmodule

// File: rtl/regfile_exec_unit.sv
// Register file with a sequencing ALU: one op in flight, single-cycle ALU
// ops, bit-serial shifts, block-owned flag register.
module regfile_exec_unit
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int SW    = $clog2(WIDTH),
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       opcode,
  input  logic [AW-1:0]    rdest,
  input  logic [AW-1:0]    rsrc,
  input  logic [7:0]       imm,
  output logic             done,
  output logic             illegal,
  output logic [4:0]       flags,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e                   state_q, state_d;
  logic [SW-1:0]            cnt_q, cnt_d;
  logic [4:0]               flags_q, flags_d;
  logic [7:0]               opc_q, opc_d;
  logic [AW-1:0]            rd_q, rd_d;
  logic signed [WIDTH-1:0]  a_q, a_d;
  logic signed [WIDTH-1:0]  b_q, b_d;

  logic                     we;
  logic [WIDTH-1:0]         wdata;
  logic [WIDTH-1:0]         ra_data, rb_data;
  logic signed [WIDTH-1:0]  imm_ext, b_sel;
  logic [WIDTH:0]           add_sum, adc_sum;
  logic [WIDTH-1:0]         sub_res;

  function automatic logic add_ovf(input logic [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [7:0] op,
                                                 input logic [WIDTH-1:0] x);
    case (op)
      OP_LSH, OP_LSHI: return {x[WIDTH-2:0], 1'b0};
      OP_RSH, OP_RSHI: return {1'b0, x[WIDTH-1:1]};
      default:         return {x[WIDTH-1], x[WIDTH-1:1]};
    endcase
  endfunction

  regfile_bank #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_bank (
    .clk      (clk),
    .rst_n    (reset),
    .we       (we),
    .waddr    (rd_q),
    .wdata    (wdata),
    .ra_addr  (rdest),
    .ra_data  (ra_data),
    .rb_addr  (rsrc),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign imm_ext = {{(WIDTH-8){imm[7]}}, imm};
  assign b_sel   = is_imm(opcode) ? imm_ext : rb_data;
  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  assign adc_sum = add_sum + {{WIDTH{1'b0}}, flags_q[FLAG_C]};
  assign sub_res = a_q - b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    opc_d   = opc_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    we      = 1'b0;
    wdata   = a_q;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          opc_d   = opcode;
          rd_d    = rdest;
          a_d     = ra_data;
          b_d     = b_sel;
          // A zero shift amount still performs one step.
          cnt_d   = (b_sel[SW-1:0] == '0) ? SW'(1) : b_sel[SW-1:0];
          state_d = is_shift(opcode) ? ST_SHIFT : ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_DONE;
        case (opc_q)
          OP_ADD, OP_ADDI: begin
            we              = 1'b1;
            wdata           = add_sum[WIDTH-1:0];
            flags_d         = '0;
            flags_d[FLAG_Z] = (add_sum[WIDTH-1:0] == '0);
            flags_d[FLAG_F] = add_ovf(a_q, b_q, add_sum[WIDTH-1:0]);
          end
          OP_ADDU: begin
            we              = 1'b1;
            wdata           = add_sum[WIDTH-1:0];
            flags_d         = '0;
            flags_d[FLAG_Z] = (add_sum[WIDTH-1:0] == '0);
            flags_d[FLAG_C] = add_sum[WIDTH];
          end
          OP_ADDC: begin
            we              = 1'b1;
            wdata           = adc_sum[WIDTH-1:0];
            flags_d         = '0;
            flags_d[FLAG_Z] = (adc_sum[WIDTH-1:0] == '0);
            flags_d[FLAG_C] = adc_sum[WIDTH];
            flags_d[FLAG_F] = add_ovf(a_q, b_q, adc_sum[WIDTH-1:0]);
          end
          OP_SUB, OP_SUBI: begin
            we              = 1'b1;
            wdata           = sub_res;
            flags_d         = '0;
            flags_d[FLAG_Z] = (sub_res == '0);
            flags_d[FLAG_F] = sub_ovf(a_q, b_q, sub_res);
          end
          OP_CMP, OP_CMPI, OP_CMPU: begin
            flags_d         = '0;
            flags_d[FLAG_Z] = (a_q == b_q);
            flags_d[FLAG_L] = ($unsigned(a_q) < $unsigned(b_q));
            flags_d[FLAG_N] = (a_q < b_q);
          end
          OP_AND: begin we = 1'b1; wdata = a_q & b_q; end
          OP_OR:  begin we = 1'b1; wdata = a_q | b_q; end
          OP_XOR: begin we = 1'b1; wdata = a_q ^ b_q; end
          OP_NOT: begin we = 1'b1; wdata = ~a_q;      end
          default: ;
        endcase
      end

      ST_SHIFT: begin
        a_d = shift_one(opc_q, a_q);
        if (cnt_q == SW'(1)) begin
          we      = 1'b1;
          wdata   = a_d;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  // Operand latches carry data only; they are always rewritten on accept.
  always_ff @(posedge clk) begin
    opc_q <= opc_d;
    rd_q  <= rd_d;
    a_q   <= a_d;
    b_q   <= b_d;
  end

  assign op_ready = (state_q == ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign illegal  = (state_q == ST_DONE) && !is_known(opc_q);
  assign flags    = flags_q;

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Randomized self-checking bench for regfile_exec_unit against a behavioural
// register/flag model.
module tb_regfile_exec_unit;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  opcode = 8'h00;
  logic [3:0]  rdest = 4'd0;
  logic [3:0]  rsrc = 4'd0;
  logic [7:0]  imm = 8'h00;
  logic        done;
  logic        illegal;
  logic [4:0]  flags;
  logic [3:0]  dbg_addr = 4'd0;
  logic [15:0] dbg_data;

  int unsigned ref_r [NR];
  logic [4:0]  ref_fl;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_lat;
  int          last_ill;

  regfile_exec_unit #(.WIDTH(16), .NREGS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opcode   (opcode),
    .rdest    (rdest),
    .rsrc     (rsrc),
    .imm      (imm),
    .done     (done),
    .illegal  (illegal),
    .flags    (flags),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic bit ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic bit op_is_shift(input logic [7:0] op);
    return op inside {8'h11, 8'h12, 8'h13, 8'h14, 8'h16};
  endfunction

  function automatic bit op_is_imm(input logic [7:0] op);
    return op inside {8'h01, 8'h09, 8'h0B, 8'h12, 8'h14};
  endfunction

  function automatic void model(input logic [7:0] op, input int unsigned a, input int unsigned b,
                                input logic [4:0] fl, output bit wr, output int unsigned res,
                                output logic [4:0] nfl, output bit ill);
    int sa, sb, n, sr;
    int unsigned s;
    sa = sx(a);
    sb = sx(b);
    wr = 1'b1;
    ill = 1'b0;
    nfl = fl;
    res = 0;
    n = int'(b % 16);
    if (n == 0) n = 1;
    case (op)
      8'h00, 8'h01: begin
        s = a + b; res = s % 65536;
        nfl = {res == 0, 1'b0, ovf(sa + sb), 2'b00};
      end
      8'h02: begin
        s = a + b; res = s % 65536;
        nfl = {res == 0, s > 65535, 3'b000};
      end
      8'h04: begin
        s = a + b + 32'(fl[3]); res = s % 65536;
        nfl = {res == 0, s > 65535, ovf(sa + sb + int'(fl[3])), 2'b00};
      end
      8'h08, 8'h09: begin
        res = (a + 65536 - b) % 65536;
        nfl = {res == 0, 1'b0, ovf(sa - sb), 2'b00};
      end
      8'h0A, 8'h0B, 8'h0C: begin
        wr = 1'b0;
        nfl = {a == b, 1'b0, 1'b0, a < b, sa < sb};
      end
      8'h0D: res = a & b;
      8'h0E: res = a | b;
      8'h0F: res = a ^ b;
      8'h10: res = (~a) & 32'hFFFF;
      8'h11, 8'h12: res = (a << n) % 65536;
      8'h13, 8'h14: res = a >> n;
      8'h16: begin sr = sa >>> n; res = int'(sr) & 32'hFFFF; end
      8'h17: wr = 1'b0;
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = 4'(i);
      #1;
      check(tag, 32'(dbg_data), ref_r[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [7:0] op, input int rd, input int rs, input logic [7:0] im);
    int unsigned a, b, res;
    bit wr, ill;
    logic [4:0] nfl;
    int lat, exp_lat, n;
    a = ref_r[rd];
    b = op_is_imm(op) ? (im[7] ? (32'hFF00 | 32'(im)) : 32'(im)) : ref_r[rs];
    model(op, a, b, ref_fl, wr, res, nfl, ill);
    n = int'(b % 16);
    if (n == 0) n = 1;
    exp_lat = op_is_shift(op) ? n : 1;
    opcode = op; rdest = 4'(rd); rsrc = 4'(rs); imm = im; op_valid = 1'b1;
    lat = 0;
    while (!op_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    check("ready_wait", 32'(op_ready), 1);
    @(posedge clk); #1;
    check("busy_after_accept", 32'(op_ready), 0);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    last_lat = lat;
    last_ill = int'(illegal);
    check("done_latency", lat, exp_lat);
    check("illegal", 32'(illegal), 32'(ill));
    check("ready_during_done", 32'(op_ready), 0);
    op_valid = 1'b0;
    if (wr) ref_r[rd] = res;
    ref_fl = nfl;
    dbg_addr = 4'(rd);
    #1;
    check("rd_value", 32'(dbg_data), ref_r[rd]);
    check("flags", 32'(flags), 32'(ref_fl));
    @(posedge clk); #1;
    check("done_single", 32'(done), 0);
    check("ready_back", 32'(op_ready), 1);
  endtask

  logic [7:0] op_tab [19] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h09, 8'h0A,
                              8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11,
                              8'h12, 8'h13, 8'h14, 8'h16, 8'h17};

  initial begin
    int dones;
    logic [7:0] rop;
    for (int i = 0; i < NR; i++) ref_r[i] = 0;
    ref_fl = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 0);
    check("rst_illegal", 32'(illegal), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(op_ready), 1);
    check("rst_flags", 32'(flags), 0);
    check_all("rst_reg");

    // R1 = 0x7FFF, R2 = 1, then ADD overflow.
    do_op(8'h01, 1, 0, 8'hFF);
    do_op(8'h14, 1, 0, 8'h01);
    do_op(8'h01, 2, 0, 8'h01);
    do_op(8'h00, 1, 2, 8'h00);
    dbg_addr = 4'd1; #1;
    check("add_res", 32'(dbg_data), 32'h8000);
    check("add_F", 32'(flags[2]), 1);
    check("add_Z", 32'(flags[4]), 0);
    check("add_lat", last_lat, 1);

    do_op(8'h01, 3, 0, 8'hFF);
    do_op(8'h02, 3, 2, 8'h00);
    dbg_addr = 4'd3; #1;
    check("addu_res", 32'(dbg_data), 0);
    check("addu_ZC", 32'(flags[4:3]), 32'b11);
    do_op(8'h04, 3, 0, 8'h00);
    dbg_addr = 4'd3; #1;
    check("addc_res", 32'(dbg_data), 1);
    check("addc_C", 32'(flags[3]), 0);

    do_op(8'h01, 4, 0, 8'h05);
    do_op(8'h0B, 4, 0, 8'hFF);
    dbg_addr = 4'd4; #1;
    check("cmpi_reg", 32'(dbg_data), 5);
    check("cmpi_flags", 32'(flags), 32'b00010);

    do_op(8'h01, 5, 0, 8'hFF);
    do_op(8'h14, 5, 0, 8'h01);
    do_op(8'h01, 5, 0, 8'h02);
    do_op(8'h01, 6, 0, 8'h03);
    do_op(8'h16, 5, 6, 8'h00);
    dbg_addr = 4'd5; #1;
    check("arsh_res", 32'(dbg_data), 32'hF000);
    check("arsh_lat", last_lat, 3);
    do_op(8'h11, 2, 0, 8'h00);
    dbg_addr = 4'd2; #1;
    check("lsh0_res", 32'(dbg_data), 2);
    check("lsh0_lat", last_lat, 1);

    do_op(8'h1F, 1, 2, 8'h00);
    check("illegal_seen", last_ill, 1);
    check_all("after_illegal");

    // Hold op_valid across a whole busy window: exactly one accept.
    opcode = 8'h01; rdest = 4'd7; rsrc = 4'd0; imm = 8'h01; op_valid = 1'b1;
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    op_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    ref_r[7] = (ref_r[7] + 1) % 65536;
    ref_fl = {ref_r[7] == 0, 4'b0000};
    check("hold_dones", dones, 1);
    dbg_addr = 4'd7; #1;
    check("hold_value", 32'(dbg_data), ref_r[7]);
    check("hold_flags", 32'(flags), 32'(ref_fl));

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 19) == 19) rop = 8'($urandom_range(0, 255));
      else rop = op_tab[$urandom_range(0, 18)];
      do_op(rop, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 8'($urandom));
      if (k % 40 == 39) check_all("rand_sweep");
    end
    check_all("rand_final");

    // Abort a long shift with reset.
    opcode = 8'h12; rdest = 4'd2; imm = 8'h0F; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) ref_r[i] = 0;
    ref_fl = '0;
    check("midrst_done", 32'(done), 0);
    check("midrst_ready", 32'(op_ready), 1);
    check("midrst_flags", 32'(flags), 0);
    check_all("midrst_reg");
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle", 32'(op_ready), 1);
    check_all("midrst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
